// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the integer register file
package regfile_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 2 ** REG_ADDR_WIDTH;

  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - register file bundle between decode/writeback and storage
interface regfile_if;
  import regfile_pkg::*;

  logic      clk;
  logic      reset;
  logic      rd0_en;
  reg_addr_t rd0_addr;
  reg_data_t rd0_data;
  logic      rd1_en;
  reg_addr_t rd1_addr;
  reg_data_t rd1_data;
  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;

  modport regfile (
    input  clk, reset,
    input  rd0_en, rd0_addr, rd1_en, rd1_addr,
    input  wr_en, wr_addr, wr_data,
    output rd0_data, rd1_data
  );

  modport client (
    output clk, reset,
    output rd0_en, rd0_addr, rd1_en, rd1_addr,
    output wr_en, wr_addr, wr_data,
    input  rd0_data, rd1_data
  );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - registered read port with x0 masking and write-first bypass
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      en_i,
  input  reg_addr_t addr_i,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  reg_data_t wr_data_i,
  input  reg_data_t mem_data_i,
  output reg_data_t rd_data_o
);

  reg_data_t data_q, data_d;

  // x0 wins over the bypass so a same-edge write to x0 can never leak out
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      if (addr_i == '0) begin
        data_d = '0;
      end else if (wr_en_i && (wr_addr_i == addr_i)) begin
        data_d = wr_data_i;
      end else begin
        data_d = mem_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/register32bit_file.sv
// rtl/register32bit_file.sv - 32x32 RISC-V integer register file, two registered reads, one write
module register32bit_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
)
(
  regfile_if.regfile reg_if
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NREGS];

  // Entry 0 is cleared on reset and never written, so it always holds zero
  always_ff @(posedge reg_if.clk) begin
    if (reg_if.reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (reg_if.wr_en && (reg_if.wr_addr != '0)) begin
      mem_q[reg_if.wr_addr] <= reg_if.wr_data;
    end
  end

  regfile_read_port u_rd0 (
    .clk_i      (reg_if.clk),
    .reset_i    (reg_if.reset),
    .en_i       (reg_if.rd0_en),
    .addr_i     (reg_if.rd0_addr),
    .wr_en_i    (reg_if.wr_en),
    .wr_addr_i  (reg_if.wr_addr),
    .wr_data_i  (reg_if.wr_data),
    .mem_data_i (mem_q[reg_if.rd0_addr]),
    .rd_data_o  (reg_if.rd0_data)
  );

  regfile_read_port u_rd1 (
    .clk_i      (reg_if.clk),
    .reset_i    (reg_if.reset),
    .en_i       (reg_if.rd1_en),
    .addr_i     (reg_if.rd1_addr),
    .wr_en_i    (reg_if.wr_en),
    .wr_addr_i  (reg_if.wr_addr),
    .wr_data_i  (reg_if.wr_data),
    .mem_data_i (mem_q[reg_if.rd1_addr]),
    .rd_data_o  (reg_if.rd1_data)
  );

endmodule

// File: tb/tb_register32bit_file.sv
// tb/tb_register32bit_file.sv - directed vector bench for register32bit_file
module tb_register32bit_file;
  import regfile_pkg::*;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e0;
    logic [4:0]  a0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] x0;
    logic [31:0] x1;
  } vec_t;

  regfile_if rif ();

  register32bit_file dut (
    .reg_if (rif)
  );

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  initial rif.clk = 1'b0;
  always #5 rif.clk = ~rif.clk;

  task automatic add(input string name, input logic rst, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic e0, input logic [4:0] a0,
                     input logic e1, input logic [4:0] a1,
                     input logic [31:0] x0, input logic [31:0] x1);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.e0 = e0; v.a0 = a0; v.e1 = e1; v.a1 = a1; v.x0 = x0; v.x1 = x1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, clock once, sample 1 time unit after the next edge
  task automatic drive_and_step(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic e0, input logic [4:0] a0,
                                input logic e1, input logic [4:0] a1);
    rif.reset = rst; rif.wr_en = we; rif.wr_addr = wa; rif.wr_data = wd;
    rif.rd0_en = e0; rif.rd0_addr = a0; rif.rd1_en = e1; rif.rd1_addr = a1;
    @(posedge rif.clk);
    #1;
  endtask

  initial begin
    rif.reset = 1'b0; rif.wr_en = 1'b0; rif.wr_addr = '0; rif.wr_data = '0;
    rif.rd0_en = 1'b0; rif.rd0_addr = '0; rif.rd1_en = 1'b0; rif.rd1_addr = '0;

    //   name            rst we wa  wd             e0 a0  e1 a1  exp0           exp1
    add("reset",         1, 0, 0,  32'h0,         0, 0,  0, 0,  32'h0,         32'h0);
    add("wr_x5",         0, 1, 5,  32'hDEADBEEF,  0, 0,  0, 0,  32'h0,         32'h0);
    add("rd_x5_pre",     0, 0, 0,  32'h0,         1, 5,  1, 5,  32'hDEADBEEF,  32'hDEADBEEF);
    add("rst_wr_rd",     1, 1, 5,  32'h55555555,  1, 5,  1, 5,  32'h0,         32'h0);
    add("rd_x5_cleared", 0, 0, 0,  32'h0,         1, 5,  1, 5,  32'h0,         32'h0);
    add("wr_x5_post",    0, 1, 5,  32'h00000077,  0, 0,  0, 0,  32'h0,         32'h0);
    add("rd_x5_post",    0, 0, 0,  32'h0,         0, 0,  1, 5,  32'h0,         32'h00000077);
    add("wr_x1",         0, 1, 1,  32'h12345678,  0, 0,  0, 0,  32'h0,         32'h00000077);
    add("wr_x31_rd_x1",  0, 1, 31, 32'hCAFEF00D,  1, 1,  0, 0,  32'h12345678,  32'h00000077);
    add("rd_x1_x31",     0, 0, 0,  32'h0,         1, 1,  1, 31, 32'h12345678,  32'hCAFEF00D);
    add("wr_x0",         0, 1, 0,  32'hFFFFFFFF,  0, 0,  0, 0,  32'h12345678,  32'hCAFEF00D);
    add("rd_x0",         0, 0, 0,  32'h0,         1, 0,  1, 0,  32'h0,         32'h0);
    add("rd_x1_x31_b",   0, 0, 0,  32'h0,         1, 1,  1, 31, 32'h12345678,  32'hCAFEF00D);
    add("x0_collision",  0, 1, 0,  32'hFFFFFFFF,  1, 0,  1, 0,  32'h0,         32'h0);
    add("wr_x7",         0, 1, 7,  32'h11111111,  0, 0,  0, 0,  32'h0,         32'h0);
    add("bypass_p0",     0, 1, 7,  32'h22222222,  1, 7,  1, 1,  32'h22222222,  32'h12345678);
    add("rd_x7_landed",  0, 0, 0,  32'h0,         1, 7,  1, 7,  32'h22222222,  32'h22222222);
    add("bypass_both",   0, 1, 7,  32'h33333333,  1, 7,  1, 7,  32'h33333333,  32'h33333333);
    add("wr_x3",         0, 1, 3,  32'hA5A5A5A5,  0, 0,  0, 0,  32'h33333333,  32'h33333333);
    add("rd1_x3",        0, 0, 0,  32'h0,         0, 0,  1, 3,  32'h33333333,  32'hA5A5A5A5);
    add("hold_rd1",      0, 1, 3,  32'h0,         0, 0,  0, 4,  32'h33333333,  32'hA5A5A5A5);
    add("rd_x3_zeroed",  0, 0, 0,  32'h0,         0, 0,  1, 3,  32'h33333333,  32'h0);
    add("no_wr_bypass",  0, 0, 1,  32'hBAD0BAD0,  1, 1,  0, 0,  32'h12345678,  32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_and_step(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                     vecs[i].e0, vecs[i].a0, vecs[i].e1, vecs[i].a1);
      check({vecs[i].name, ".rd0"}, rif.rd0_data, vecs[i].x0);
      check({vecs[i].name, ".rd1"}, rif.rd1_data, vecs[i].x1);
    end

    for (int i = 1; i < 32; i++) begin
      drive_and_step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 31; i >= 0; i--) begin
      drive_and_step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      check($sformatf("sweep.rd0[%0d]", i), rif.rd0_data, 32'(i) * 32'h01010101);
      check($sformatf("sweep.rd1[%0d]", 31 - i), rif.rd1_data, 32'(31 - i) * 32'h01010101);
    end

    drive_and_step(1'b1, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd31, 1'b1, 5'd9);
    check("final_reset.rd0", rif.rd0_data, 32'h0);
    check("final_reset.rd1", rif.rd1_data, 32'h0);
    drive_and_step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd9);
    check("after_reset.x31", rif.rd0_data, 32'h0);
    check("after_reset.x9", rif.rd1_data, 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
